// File: rtl/sloth_eval_pkg.sv
// Shared types, constants and the LFSR/MISR step functions for the
// candidate evaluation driver.
package sloth_eval_pkg;

  localparam int W = 16;
  localparam logic [W-1:0] SEED_DEFAULT = 16'hACE1;

  // Feedback taps at bits 15, 13, 12 and 10 for both the generator and the compactor.
  localparam logic [W-1:0] LFSR_TAPS = 16'hB400;
  localparam logic [W-1:0] MISR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] s);
    return {s[W-2:0], ^(s & LFSR_TAPS)};
  endfunction

  function automatic logic [W-1:0] misr_step(
    input logic [W-1:0] sig,
    input logic [W-1:0] y3,
    input logic [W-1:0] y2,
    input logic [W-1:0] y1,
    input logic [W-1:0] y0
  );
    logic [W-1:0] folded;
    folded = y3 ^ {y2[W-2:0], y2[W-1]} ^ {y1[W-3:0], y1[W-1:W-2]} ^ {y0[W-4:0], y0[W-1:W-3]};
    return {sig[W-2:0], ^(sig & MISR_TAPS)} ^ folded;
  endfunction

endpackage

// File: rtl/sloth_eval_driver_lfsr4.sv
// Operand generator: advances the LFSR four steps per cycle and registers
// the four intermediate states as one operand vector.
module sloth_lfsr4
  import sloth_eval_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] seed_val,
  output logic [W-1:0] a1,
  output logic [W-1:0] a0,
  output logic [W-1:0] b1,
  output logic [W-1:0] b0
);

  logic [W-1:0] s_reg;
  logic [W-1:0] chain [0:4];

  assign chain[0] = load ? seed_val : s_reg;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_step
      assign chain[gi+1] = lfsr_step(chain[gi]);
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_reg <= '0;
      a0    <= '0;
      a1    <= '0;
      b0    <= '0;
      b1    <= '0;
    end else if (load || step) begin
      a0    <= chain[1];
      a1    <= chain[2];
      b0    <= chain[3];
      b1    <= chain[4];
      s_reg <= chain[4];
    end
  end

endmodule

// File: rtl/sloth_eval_driver.sv
// Evaluation harness: drives pseudo-random vectors into one candidate and
// compacts its responses into a MISR signature.
module sloth_eval_driver
  import sloth_eval_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] n_vectors,
  input  logic [W-1:0] seed,
  output logic [W-1:0] a1,
  output logic [W-1:0] a0,
  output logic [W-1:0] b1,
  output logic [W-1:0] b0,
  input  logic [W-1:0] y3,
  input  logic [W-1:0] y2,
  input  logic [W-1:0] y1,
  input  logic [W-1:0] y0,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] vec_count,
  output logic [W-1:0] signature
);

  state_t       state_reg, state_next;
  logic [W-1:0] n_reg, n_next;
  logic [W-1:0] cnt_reg, cnt_next;
  logic [W-1:0] sig_reg, sig_next;
  logic [W-1:0] cnt_inc;
  logic [W-1:0] seed_val;
  logic         gen_load, gen_step;

  assign seed_val = (seed == '0) ? SEED_DEFAULT : seed;
  assign cnt_inc  = cnt_reg + 16'd1;

  sloth_lfsr4 u_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (gen_load),
    .step     (gen_step),
    .seed_val (seed_val),
    .a1       (a1),
    .a0       (a0),
    .b1       (b1),
    .b0       (b0)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      n_reg     <= '0;
      cnt_reg   <= '0;
      sig_reg   <= '0;
    end else begin
      state_reg <= state_next;
      n_reg     <= n_next;
      cnt_reg   <= cnt_next;
      sig_reg   <= sig_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    n_next     = n_reg;
    cnt_next   = cnt_reg;
    sig_next   = sig_reg;
    gen_load   = 1'b0;
    gen_step   = 1'b0;
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          cnt_next = '0;
          sig_next = '0;
          n_next   = n_vectors;
          if (n_vectors != '0) begin
            gen_load   = 1'b1;
            state_next = RUN;
          end else begin
            state_next = DONE;
          end
        end
      end
      RUN: begin
        // Abort wins over absorbing the vector currently on the operands.
        if (abort) begin
          state_next = IDLE;
        end else begin
          sig_next = misr_step(sig_reg, y3, y2, y1, y0);
          cnt_next = cnt_inc;
          if (cnt_inc == n_reg) begin
            state_next = DONE;
          end else begin
            gen_step = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy      = (state_reg == RUN);
  assign done      = (state_reg == DONE);
  assign vec_count = cnt_reg;
  assign signature = sig_reg;

endmodule

// File: tb/tb_sloth_eval_driver.sv
// Randomized bench for sloth_eval_driver with a vector-list reference model
// and a behavioural candidate driving the y inputs.
module tb_sloth_eval_driver;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort;
  logic [15:0] n_vectors, seed;
  logic [15:0] a1, a0, b1, b0;
  logic [15:0] y3, y2, y1, y0;
  logic        busy, done;
  logic [15:0] vec_count, signature;

  bit          const_mode;
  logic [63:0] cvals;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  sloth_eval_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .n_vectors (n_vectors),
    .seed      (seed),
    .a1        (a1),
    .a0        (a0),
    .b1        (b1),
    .b0        (b0),
    .y3        (y3),
    .y2        (y2),
    .y1        (y1),
    .y0        (y0),
    .busy      (busy),
    .done      (done),
    .vec_count (vec_count),
    .signature (signature)
  );

  function automatic logic [15:0] cand(input int idx, input logic [15:0] p1, p0, q1, q0,
                                       input bit cm, input logic [63:0] cv);
    if (cm) return cv[idx*16 +: 16];
    case (idx)
      3:       return p1 + q1;
      2:       return p0 ^ q0;
      1:       return (p0 & q1) | {q0[7:0], p1[15:8]};
      default: return p1 - q0;
    endcase
  endfunction

  assign y3 = cand(3, a1, a0, b1, b0, const_mode, cvals);
  assign y2 = cand(2, a1, a0, b1, b0, const_mode, cvals);
  assign y1 = cand(1, a1, a0, b1, b0, const_mode, cvals);
  assign y0 = cand(0, a1, a0, b1, b0, const_mode, cvals);

  function automatic logic [15:0] lfsr_ref(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

  function automatic logic [15:0] rot(input logic [15:0] v, input int k);
    logic [31:0] d;
    d = {v, v} << k;
    return d[31:16];
  endfunction

  function automatic logic [15:0] misr_ref(input logic [15:0] sig, input logic [15:0] r3, r2, r1, r0);
    return lfsr_ref(sig) ^ r3 ^ rot(r2, 1) ^ rot(r1, 2) ^ rot(r0, 3);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Runs one evaluation; abort_at >= 0 aborts while vec_count == abort_at.
  task automatic run_eval(input logic [15:0] sd, input int n, input int abort_at,
                          input bit noise, output logic [15:0] sig_out);
    logic [15:0] s, sig, ea0, ea1, eb0, eb1;
    s   = (sd == 16'h0) ? 16'hACE1 : sd;
    sig = 16'h0;
    seed = sd;
    n_vectors = n[15:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    sig_out = 16'h0;
    if (n == 0) begin
      chk("zero_done", {63'b0, done}, 64'd1);
      chk("zero_busy", {63'b0, busy}, 64'd0);
      chk("zero_sig", {48'b0, signature}, 64'd0);
      chk("zero_cnt", {48'b0, vec_count}, 64'd0);
      $display("run seed=%h n=0 sig=%h", sd, signature);
      return;
    end
    for (int k = 0; k < n; k++) begin
      ea0 = lfsr_ref(s);
      ea1 = lfsr_ref(ea0);
      eb0 = lfsr_ref(ea1);
      eb1 = lfsr_ref(eb0);
      s   = eb1;
      chk("run_busy", {63'b0, busy}, 64'd1);
      chk("run_ops", {a1, a0, b1, b0}, {ea1, ea0, eb1, eb0});
      chk("run_cnt", {48'b0, vec_count}, 64'(k));
      if (k == abort_at) begin
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_busy", {62'b0, busy, done}, 64'd0);
        chk("abort_cnt", {48'b0, vec_count}, 64'(k));
        chk("abort_sig", {48'b0, signature}, {48'b0, sig});
        chk("abort_ops", {a1, a0, b1, b0}, {ea1, ea0, eb1, eb0});
        sig_out = sig;
        $display("run seed=%h n=%0d aborted at %0d sig=%h", sd, n, k, signature);
        return;
      end
      sig = misr_ref(sig, cand(3, ea1, ea0, eb1, eb0, const_mode, cvals),
                     cand(2, ea1, ea0, eb1, eb0, const_mode, cvals),
                     cand(1, ea1, ea0, eb1, eb0, const_mode, cvals),
                     cand(0, ea1, ea0, eb1, eb0, const_mode, cvals));
      if (noise) begin
        start = 1'($urandom_range(0, 1));
        n_vectors = 16'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      n_vectors = n[15:0];
    end
    chk("end_done", {62'b0, busy, done}, 64'd1);
    chk("end_cnt", {48'b0, vec_count}, 64'(n));
    chk("end_sig", {48'b0, signature}, {48'b0, sig});
    chk("end_ops", {a1, a0, b1, b0}, {ea1, ea0, eb1, eb0});
    @(posedge clk); #1;
    chk("hold_sig", {47'b0, done, signature}, {47'b0, 1'b1, sig});
    sig_out = sig;
    $display("run seed=%h n=%0d sig=%h", sd, n, signature);
  endtask

  initial begin
    logic [15:0] sg, sg_abort, sg_full, rseed;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    n_vectors = 16'h0; seed = 16'h0;
    const_mode = 1'b1; cvals = 64'h0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ops", {a1, a0, b1, b0}, 64'h0);
    chk("rst_out", {30'b0, busy, done, vec_count, signature}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Default seed, single vector, checked against known constants.
    seed = 16'h0; n_vectors = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("dflt_a0", {48'b0, a0}, 64'h59C3);
    chk("dflt_a1", {48'b0, a1}, 64'hB387);
    chk("dflt_busy", {62'b0, busy, done}, 64'd2);
    @(posedge clk); #1;
    chk("dflt_done", {62'b0, busy, done}, 64'd1);
    chk("dflt_cnt", {48'b0, vec_count}, 64'd1);
    $display("run seed=0000 n=1 sig=%h", signature);

    // Constant candidate responses exercise the MISR fold.
    cvals = {16'h0001, 16'h0, 16'h0, 16'h0};
    run_eval(16'h0, 1, -1, 1'b0, sg);
    chk("misr_y3_n1", {48'b0, sg}, 64'h0001);
    run_eval(16'h1234, 2, -1, 1'b0, sg);
    chk("misr_y3_n2", {48'b0, sg}, 64'h0003);
    cvals = {16'h0, 16'h0, 16'h0, 16'h0001};
    run_eval(16'h0, 1, -1, 1'b0, sg);
    chk("misr_y0_rot", {48'b0, sg}, 64'h0008);

    const_mode = 1'b0;
    run_eval(16'h0, 0, -1, 1'b0, sg);

    for (int i = 0; i < 6; i++) begin
      run_eval(16'($urandom), int'($urandom_range(1, 20)), -1, 1'b1, sg);
    end

    // Abort then rerun from the same seed.
    rseed = 16'($urandom);
    run_eval(rseed, 100, 10, 1'b0, sg_abort);
    repeat (2) @(posedge clk);
    #1;
    chk("idle_after_abort", {62'b0, busy, done}, 64'd0);
    run_eval(rseed, 100, -1, 1'b0, sg_full);
    run_eval(rseed, 100, -1, 1'b1, sg);
    chk("rerun_same_sig", {48'b0, signature}, {48'b0, sg_full});

    // Reset mid-run.
    seed = 16'h5A5A; n_vectors = 16'd50; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_ops", {a1, a0, b1, b0}, 64'h0);
    chk("midrst_out", {30'b0, busy, done, vec_count, signature}, 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_eval(16'h5A5A, 3, -1, 1'b0, sg);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
